// File: rtl/icache_direct_mapped.sv
// Direct-mapped, read-only instruction cache, one word per frame.
// A hit returns data in the same cycle. A miss fetches one word over the
// iREN/iaddr/iwait/iload handshake, fills the frame, and then hits.
module icache_direct_mapped #(
  parameter  int SETS  = 16,
  localparam int IDX_W = $clog2(SETS),
  localparam int TAG_W = 30 - IDX_W
) (
  input  logic        CLK,
  input  logic        RST,
  // datapath fetch port
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  // memory controller instruction port
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MISS = 1'b1
  } state_t;

  state_t             r_state;
  logic [TAG_W-1:0]   r_miss_tag;
  logic [IDX_W-1:0]   r_miss_idx;

  logic               r_valid [SETS];
  logic [TAG_W-1:0]   r_tag   [SETS];
  logic [31:0]        r_data  [SETS];

  logic [IDX_W-1:0]   w_idx;
  logic [TAG_W-1:0]   w_tag;
  logic               w_match;
  logic               w_fill;
  logic [SETS-1:0]    w_we;
  logic [1:0]         w_unused_offset;

  // Address split; the byte offset does not select anything in a word cache.
  assign w_idx           = imemaddr[IDX_W+1:2];
  assign w_tag           = imemaddr[31:IDX_W+2];
  assign w_unused_offset = imemaddr[1:0];

  // Lookup is combinational; a hit is only reported while idle.
  assign w_match  = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign ihit     = imemREN && w_match && (r_state == S_IDLE);
  assign imemload = r_data[w_idx];

  // Memory request comes purely from registers, so it is glitch-free and
  // stays fixed for the whole miss regardless of the datapath address.
  assign iREN  = (r_state == S_MISS);
  assign iaddr = {r_miss_tag, r_miss_idx, 2'b00};

  // The fill completes on the first MISS cycle with memory not busy.
  assign w_fill = (r_state == S_MISS) && !iwait;

  // One write-enable per frame, selected by the latched miss index.
  generate
    for (genvar gi = 0; gi < SETS; gi++) begin : g_we
      assign w_we[gi] = w_fill && (r_miss_idx == IDX_W'(gi));
    end
  endgenerate

  // Miss FSM: latch the missing address in IDLE, wait out memory in MISS.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state    <= S_IDLE;
      r_miss_tag <= '0;
      r_miss_idx <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (imemREN && !w_match) begin
            r_miss_tag <= w_tag;
            r_miss_idx <= w_idx;
            r_state    <= S_MISS;
          end
        end
        S_MISS: begin
          if (!iwait) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Frame storage: a fill overwrites whatever the frame held before.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < SETS; i++) begin
        r_valid[i] <= 1'b0;
        r_tag[i]   <= '0;
        r_data[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < SETS; i++) begin
        if (w_we[i]) begin
          r_valid[i] <= 1'b1;
          r_tag[i]   <= r_miss_tag;
          r_data[i]  <= iload;
        end
      end
    end
  end

endmodule

// File: doc/icache_direct_mapped.md
# icache_direct_mapped

Direct-mapped, read-only instruction cache between the datapath fetch port and the memory controller's instruction port. Serves `imemREN`/`imemaddr` requests from the datapath, returning `ihit`/`imemload` the same cycle on a hit. On a miss it fetches one word from memory over the `iREN`/`iaddr`/`iwait`/`iload` handshake, fills the frame, and then hits. Data is never written by the datapath, so there is no dirty state and no write-back.

## Interface
- `SETS`, 16: number of frames, a power of two ≥ 2; `IDX_W = log2(SETS)`.
- `CLK`  in  1  rising-edge clock.
- `RST`  in  1  asynchronous, active-high reset.
- `imemREN`  in  1  datapath fetch request.
- `imemaddr`  in  32  fetch byte address; bits [1:0] ignored.
- `ihit`  out  1  requested word valid on `imemload` this cycle.
- `imemload`  out  32  instruction word.
- `iREN`  out  1  memory read request.
- `iaddr`  out  32  memory word address, bits [1:0] = 0.
- `iwait`  in  1  memory busy; low means `iload` valid this cycle.
- `iload`  in  32  memory read data.

## Operation
- Address split:
  - byte offset = `imemaddr[1:0]`
  - index = `imemaddr[IDX_W+1:2]`
  - tag = `imemaddr[31:IDX_W+2]`
- Each frame holds a valid bit, a tag and a 32-bit data word. One word per block.
- There are two states, IDLE and MISS.
- In IDLE:
  - `ihit = imemREN & valid[idx] & (tag[idx] == tag)`; `imemload = data[idx]`. Both are combinational.
  - If `imemREN & !hit`: latch `{tag, idx}` into the miss address register and go to MISS.
  - `iREN = 0`.
- In MISS:
  - `iREN = 1` and `iaddr = {miss_tag, miss_idx, 2'b00}`, driven from the latched register, not from `imemaddr`.
  - `ihit = 0`.
  - On a clock edge with `iwait == 0`: write `valid = 1`, the tag, and `data = iload` into frame `miss_idx`, then go to IDLE.
  - While `iwait == 1`, stay in MISS with all outputs held stable.
- A fill always completes once started. Changes to `imemaddr`, or deassertion of `imemREN`, during MISS do not abort or retarget the fill. The new address is evaluated in IDLE after the fill.
- When `imemREN == 0`, `imemload` still shows `data[idx]`, but `ihit = 0` and no miss starts.
- A fill replaces a valid frame with a different tag unconditionally (direct-mapped eviction).
- Reset, asynchronous:
  - all valid bits = 0, tags and data = 0, state = IDLE, miss address register = 0
  - outputs: `ihit = 0`, `iREN = 0`, `iaddr = 0`, `imemload = 0`
- Reset asserted mid-MISS drops the request immediately (`iREN = 0`) and writes no frame. The memory side must tolerate an abandoned request.

## Timing
- Hit latency is 0 cycles: `ihit` and `imemload` are valid in the same cycle as `imemREN`/`imemaddr`.
- Miss, cycle by cycle:
  - Cycle 0: the miss is detected in IDLE; `ihit = 0`.
  - From cycle 1: MISS, `iREN = 1`.
  - With `iwait` low for the first time in cycle k ≥ 1, the frame is written at the end of cycle k.
  - Cycle k+1: IDLE, `ihit = 1` for the same address.
  - Minimum miss penalty is 2 cycles (k = 1).
- `iREN` never toggles while `iwait` is high. `iaddr` is constant throughout MISS.
- At most one outstanding memory request.

## Test plan
- **Reset and cold hit:** reset, then `imemREN = 1`, `imemaddr = 0x0000_0040`; memory returns `0x2408_0001` after 3 cycles of `iwait`.
  - Cycle 0: `ihit = 0`.
  - MISS: `iREN = 1`, `iaddr = 0x40`.
  - One cycle after `iwait` falls: `ihit = 1`, `imemload = 0x2408_0001`.
  - No further `iREN`.
- **Conflict eviction:** fill `0x40`, then request `0x0000_0080` (same index, different tag).
  - `0x80` misses and fills.
  - Re-request `0x40`: misses again, `iREN = 1`, `iaddr = 0x40`.
- **Address change during MISS:** miss on `0x100`; during `iwait = 1`, switch `imemaddr` to `0x204`.
  - `iaddr` stays `0x100` until the fill.
  - Frame for `0x100` is valid afterwards.
  - `0x204` then misses in IDLE.
- **Request drop:** `imemREN = 0` with any address.
  - `ihit = 0`, `iREN` never asserted.
  - Drop `imemREN` mid-MISS: the fill still completes and a later `0x100` request hits with no `iREN`.
- **Reset mid-miss:** assert `RST` while in MISS with `iwait = 1`.
  - `iREN = 0` immediately.
  - After release, the previously missing address misses again (its frame is not valid).
- **Offset ignore:** after filling `0x40`, request `0x43`.
  - `ihit = 1`, same `imemload`.
